// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUSel codes produced by the ALU decoder and
// consumed by alu_seq_exec, plus the execute-unit state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // True for the three shift codes.
  function automatic logic is_shift_op(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shift of an XLEN-wide word. Mode is the ALUSel shift code:
// SLL and SRL fill with zero, SRA replicates the sign bit. Any other code
// passes the data through unchanged.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      i_sel,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data
);

  // Select the one-position shift for the requested mode.
  always_comb begin
    o_data = i_data;
    case (i_sel)
      ALU_SLL: o_data = {i_data[XLEN-2:0], 1'b0};
      ALU_SRL: o_data = {1'b0, i_data[XLEN-1:1]};
      ALU_SRA: o_data = {i_data[XLEN-1], i_data[XLEN-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit behind a valid/ready handshake on both sides.
// Logic/arithmetic ops finish in one cycle; shifts by default run through a
// 1-bit-per-cycle serial shifter (latency 1 + shamt).
// Build option ALU_SEQ_BARREL_EN: shifts use a single-cycle barrel shifter,
// the SHIFT state and shift counter disappear, every op has latency 1.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_comb;
  logic            w_accept;

  assign w_shamt   = op_b[SHW-1:0];
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;
  assign result    = r_result;
  assign zero      = r_zero;

  // Single-cycle datapath on the live request inputs. In the serial build
  // a shift that reaches here has shamt == 0, so it simply returns A.
  always_comb begin
    w_comb = '0;
    case (alu_sel)
      ALU_ADD:  w_comb = op_a + op_b;
      ALU_SUB:  w_comb = op_a - op_b;
      ALU_SLT:  w_comb = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: w_comb = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  w_comb = op_a ^ op_b;
      ALU_OR:   w_comb = op_a | op_b;
      ALU_AND:  w_comb = op_a & op_b;
`ifdef ALU_SEQ_BARREL_EN
      ALU_SLL:  w_comb = op_a << w_shamt;
      ALU_SRL:  w_comb = op_a >> w_shamt;
      ALU_SRA:  w_comb = XLEN'($signed(op_a) >>> w_shamt);
`else
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  w_comb = op_a;
`endif
      default:  w_comb = '0;
    endcase
  end

`ifdef ALU_SEQ_BARREL_EN

  // Two-state control: every accepted request completes on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_result <= w_comb;
            r_zero   <= (w_comb == '0);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`else

  logic [3:0]      r_sel;
  logic [XLEN-1:0] r_sh;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] w_step;
  logic            w_go_shift;

  // Only a shift with a nonzero amount needs the serial path.
  assign w_go_shift = is_shift_op(alu_sel) && (w_shamt != '0);

  alu_shift_step #(.XLEN(XLEN)) u_step (
    .i_sel  (r_sel),
    .i_data (r_sh),
    .o_data (w_step)
  );

  // Control and datapath registers: the counter holds remaining shifts;
  // the last shift writes straight into the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
      r_sh     <= '0;
      r_sel    <= ALU_ADD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_go_shift) begin
              r_sh    <= op_a;
              r_cnt   <= w_shamt;
              r_sel   <= alu_sel;
              r_state <= ST_SHIFT;
            end else begin
              r_result <= w_comb;
              r_zero   <= (w_comb == '0);
              r_state  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_sh  <= w_step;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_result <= w_step;
            r_zero   <= (w_step == '0);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec (XLEN = 32): directed vector table,
// hand-written backpressure and reset-abort sequences, and randomized ops
// checked against an arithmetic reference model.
module tb_alu_seq_exec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int n_vec = 0;
  int n_err = 0;

  alu_seq_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Reference semantics written straight from the ALUSel table.
  function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] s, input logic [31:0] b);
`ifdef ALU_SEQ_BARREL_EN
    return 1;
`else
    if (s == 4'd5 || s == 4'd6 || s == 4'd7) return 1 + int'(b % 32);
    return 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One full transaction: accept, measure latency, check, then release
  // after hold_cyc cycles of backpressure.
  task automatic do_op(input string nm, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int elat,
                       input int hold_cyc);
    int t;
    int lat;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    chk({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_sel = sel; op_a = a; op_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_sel = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_result"}, result, exp);
    chk({nm, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
    repeat (hold_cyc) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_released"}, {31'b0, out_valid}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int tmo;
    int seen;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; alu_sel = 4'd0; op_a = '0; op_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result",    result,             32'd0);
    chk("reset_zero",      {31'b0, zero},      32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors: {sel, A, B, expected result, serial latency}.
    vecs.push_back('{4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1});
    vecs.push_back('{4'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1});
    vecs.push_back('{4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1});
    vecs.push_back('{4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32});
    vecs.push_back('{4'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32});
    vecs.push_back('{4'd5, 32'h1234_ABCD, 32'h0000_0000, 32'h1234_ABCD, 1});
    vecs.push_back('{4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1});
    vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    vecs.push_back('{4'd4, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1});
    vecs.push_back('{4'd8, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1});
    vecs.push_back('{4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1});
    vecs.push_back('{4'd5, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 5});
    vecs.push_back('{4'd6, 32'h0000_0080, 32'hFFFF_FF24, 32'h0000_0008, 5});
    vecs.push_back('{4'd7, 32'h7000_0000, 32'h0000_001C, 32'h0000_0007, 29});

    foreach (vecs[i]) begin
`ifdef ALU_SEQ_BARREL_EN
      do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, 1, 0);
`else
      do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
`endif
    end

    // Backpressure: hold the result 5 cycles while a new request is offered.
    @(negedge clk);
    in_valid = 1'b1; alu_sel = 4'd0; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    alu_sel = 4'd1; op_a = 32'd9; op_b = 32'd9;
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_result_c%0d", c), result, 32'd7);
      chk($sformatf("bp_zero_c%0d", c), {31'b0, zero}, 32'd0);
      chk($sformatf("bp_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("bp_ignored_request", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a 20-position SLL aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; alu_sel = 4'd5; op_a = 32'hFFFF_FFFF; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_no_out_valid", seen, 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  s;
      logic [31:0] a;
      logic [31:0] b;
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_op($sformatf("rnd%0d_sel%0d", i, s), s, a, b, ref_alu(s, a, b), ref_lat(s, b),
            int'($urandom_range(0, 3)));
    end

    // Result must hold under backpressure after a serial shift too.
    @(negedge clk);
    in_valid = 1'b1; alu_sel = 4'd7; op_a = 32'h8000_0010; op_b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tmo = 0;
    while (!out_valid && tmo < 100) begin @(posedge clk); #1; tmo++; end
    held = result;
    chk("sra_bp_value", held, 32'hF800_0001);
    repeat (3) begin @(posedge clk); #1; end
    chk("sra_bp_stable", result, 32'hF800_0001);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("sra_bp_in_ready", {31'b0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Multi-cycle execute unit and the consumer side of the 4-bit ALUSel code produced by the core's ALU decoder. It accepts operands and an ALUSel code over a valid/ready handshake and returns the result and a zero flag over a second valid/ready handshake. Logic and arithmetic ops complete in one cycle. Shifts use a 1-bit-per-cycle serial shifter to save area. It sits beside the datapath for area-reduced or multi-cycle core variants.

Parameters:
XLEN, 32, operand/result width; must be a power of two, 8 or greater.
SHW, $clog2(XLEN), shift-amount width, derived; not overridden.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
alu_sel  in  4  ALUSel code
op_a  in  XLEN  operand A
op_b  in  XLEN  operand B; op_b[SHW-1:0] is the shift amount
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  XLEN  operation result
zero  out  1  result == 0

Behaviour:
- ALUSel encoding:
  - 0000 ADD; 0001 SUB; 0010 SLT (signed); 0011 SLTU.
  - 0100 XOR; 0101 SLL; 0110 SRL; 0111 SRA; 1000 OR; 1001 AND.
  - 1010-1111 produce result 0 in one cycle; no error flag.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. SLT/SLTU return 1 or 0, zero-extended.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE). A request is accepted on any edge where in_valid && in_ready.
  - alu_sel, op_a and shamt are captured at accept. Inputs are don't-care after accept.
- IDLE, non-shift op or shamt == 0: compute, latch result, go to DONE. out_valid rises 1 cycle after accept.
- IDLE, shift op with shamt > 0: load the shift register with op_a and the counter with shamt, go to SHIFT.
- SHIFT: each edge shifts by 1 and decrements the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the MSB.
  - When the counter is 1 at an edge, go to DONE.
  - out_valid rises exactly 1 + shamt cycles after accept.
- DONE: out_valid = 1. result and zero stay stable until out_ready.
  - An edge with out_ready = 1 moves to IDLE. There is no same-cycle accept of a new request (at most one request per 2 cycles).
- zero is registered with result and is valid only while out_valid = 1.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, zero 0, counter 0.
- Reset asserted mid-operation (SHIFT or DONE) aborts immediately. The pending result is discarded and no out_valid pulse follows.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored; the requester must hold the request.

Optional Feature:
ALU_SEQ_BARREL_EN
- Defined: shifts use a single-cycle barrel shifter. The SHIFT state and counter are not synthesized. All ops have 1-cycle latency.
- Undefined: serial shifting as above, latency 1 + shamt.
- The handshake protocol is identical in both builds.

Decomposition:
- Shared package alu_pkg: the ALUSel localparams (ALU_ADD ... ALU_AND, 4-bit) and the state enum. The ALU decoder and this block both import it.
- One sub-module, alu_shift_step: combinational single-bit shift of XLEN bits with mode input (SLL/SRL/SRA). Instantiated only when ALU_SEQ_BARREL_EN is undefined.

Test Plan:
- ADD, A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid 1 cycle after accept, result 0x80000000, zero 0; SUB, A=5, B=5 -> result 0, zero 1.
- SLT, A=0xFFFFFFFF, B=1 -> result 1; SLTU with the same operands -> result 0.
- SRA, A=0x80000000, shamt=31 -> out_valid exactly 32 cycles after accept, result 0xFFFFFFFF. SRL with the same operands -> 0x00000001. SLL with shamt=0 -> 1-cycle latency, result equals A.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/zero stable, in_ready 0, new in_valid ignored. Release -> IDLE next edge, in_ready 1.
- Assert rst during SHIFT (SLL, shamt=20, cycle 7) -> asynchronously IDLE, out_valid 0, result 0. No out_valid afterwards until a new request.
- alu_sel=1111 -> result 0, zero 1, 1-cycle latency. Rerun the shift cases with ALU_SEQ_BARREL_EN defined -> same results, all 1-cycle latency.
